// File: rtl/pwm_pkg.sv
// Shared register map, CTRL field positions and bus helpers for pwm_multi.
package pwm_pkg;

  localparam logic [5:0] CTRL_IDX      = 6'h00;
  localparam logic [5:0] PERIOD_IDX    = 6'h01;
  localparam logic [5:0] STATUS_IDX    = 6'h02;
  localparam logic [5:0] DUTY_BASE_IDX = 6'h10;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_CENTER_BIT = 1;
  localparam int unsigned CTRL_PRESC_LSB  = 8;
  localparam int unsigned STATUS_DIR_BIT  = 31;

  // Widest counter the block supports; narrower counters zero-extend into it.
  localparam int unsigned CNT_W_MAX = 32;
  typedef logic [CNT_W_MAX-1:0] cnt_word_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Simple valid/ready CPU memory bus as seen by the PWM peripheral.
interface pwm_multi_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/pwm_timebase.sv
// Shared prescaler and period counter; raises load when duty shadows may update.
module pwm_timebase #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             center,
  input  logic [PRE_W-1:0] presc,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic             dir,
  output logic             load
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             tick;

  always_comb begin
    tick  = (pre_q == presc);
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = cnt_q;
    dir_d = dir_q;
    load  = 1'b0;
    if (!en) begin
      pre_d = '0;
      cnt_d = '0;
      dir_d = 1'b0;
      load  = 1'b1;
    end else if (tick) begin
      if (center && period != '0) begin
        // DIR flips on arrival at either end, so each end value lasts one tick.
        if (!dir_q) begin
          cnt_d = cnt_q + 1'b1;
          dir_d = (cnt_d == period);
        end else begin
          cnt_d = cnt_q - 1'b1;
          dir_d = (cnt_d != '0);
          load  = (cnt_d == '0);
        end
      end else begin
        load  = (cnt_q == period);
        cnt_d = load ? '0 : cnt_q + 1'b1;
        dir_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign cnt = cnt_q;
  assign dir = dir_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM bus slave with double-buffered duty registers.
// Center-aligned counting is compiled in with PWM_CENTER_ALIGN_EN.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 8
) (
  input  logic           clk,
  input  logic           resetn,
  pwm_multi_if.slave     bus,
  output logic [NCH-1:0] out
);

  typedef logic [CNT_W-1:0] cnt_t;

  logic             ctrl_en_q, ctrl_en_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  cnt_t             period_q, period_d;
  cnt_t             duty_q [NCH];
  cnt_t             duty_d [NCH];
  cnt_t             duty_act_q [NCH];
  cnt_t             duty_act_d [NCH];
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [NCH-1:0]   out_q, out_d;

  logic             center;
`ifdef PWM_CENTER_ALIGN_EN
  logic             center_q, center_d;
  assign center = center_q;
`else
  assign center = 1'b0;
`endif

  cnt_t             cnt;
  logic             dir, load;
  logic [5:0]       word;
  logic             accept, is_wr, do_wr;
  cnt_word_t        ctrl_rd, rd_word, wr_word;
  logic             unused_bits;

  pwm_timebase #(
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) u_timebase (
    .clk    (clk),
    .resetn (resetn),
    .en     (ctrl_en_q),
    .center (center),
    .presc  (presc_q),
    .period (period_q),
    .cnt    (cnt),
    .dir    (dir),
    .load   (load)
  );

  always_comb begin
    word   = bus.addr[7:2];
    accept = bus.valid && !ready_q;
    is_wr  = |bus.wstrb;
    do_wr  = accept && is_wr;

    ctrl_rd = '0;
    ctrl_rd[CTRL_EN_BIT] = ctrl_en_q;
    ctrl_rd[CTRL_CENTER_BIT] = center;
    ctrl_rd[CTRL_PRESC_LSB +: PRE_W] = presc_q;

    rd_word = '0;
    if (word == CTRL_IDX) begin
      rd_word = ctrl_rd;
    end else if (word == PERIOD_IDX) begin
      rd_word = 32'(period_q);
    end else if (word == STATUS_IDX) begin
      rd_word = 32'(cnt);
      rd_word[STATUS_DIR_BIT] = rd_word[STATUS_DIR_BIT] | dir;
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (word == DUTY_BASE_IDX + 6'(i)) rd_word = 32'(duty_q[i]);
    end

    // Byte merge over the zero-extended current value drops bits above each field.
    wr_word = merge_bytes(rd_word, bus.wdata, bus.wstrb);

    ctrl_en_d = ctrl_en_q;
    presc_d   = presc_q;
    period_d  = period_q;
`ifdef PWM_CENTER_ALIGN_EN
    center_d  = center_q;
`endif
    if (do_wr && word == CTRL_IDX) begin
      ctrl_en_d = wr_word[CTRL_EN_BIT];
      presc_d   = wr_word[CTRL_PRESC_LSB +: PRE_W];
`ifdef PWM_CENTER_ALIGN_EN
      center_d  = wr_word[CTRL_CENTER_BIT];
`endif
    end
    if (do_wr && word == PERIOD_IDX) period_d = wr_word[CNT_W-1:0];

    ready_d = accept;
    rdata_d = (accept && !is_wr) ? rd_word : '0;

    for (int unsigned i = 0; i < NCH; i++) begin
      duty_d[i]     = (do_wr && word == DUTY_BASE_IDX + 6'(i)) ? wr_word[CNT_W-1:0] : duty_q[i];
      duty_act_d[i] = load ? duty_q[i] : duty_act_q[i];
      out_d[i]      = ctrl_en_q && (cnt < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_en_q  <= 1'b0;
      presc_q    <= '0;
      period_q   <= '0;
      duty_q     <= '{default: '0};
      duty_act_q <= '{default: '0};
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      out_q      <= '0;
`ifdef PWM_CENTER_ALIGN_EN
      center_q   <= 1'b0;
`endif
    end else begin
      ctrl_en_q  <= ctrl_en_d;
      presc_q    <= presc_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      duty_act_q <= duty_act_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      out_q      <= out_d;
`ifdef PWM_CENTER_ALIGN_EN
      center_q   <= center_d;
`endif
    end
  end

  assign bus.ready   = ready_q;
  assign bus.rdata   = rdata_q;
  assign out         = out_q;
  assign unused_bits = ^{bus.addr[31:8], bus.addr[1:0], wr_word};

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus queues expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_pwm_multi;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [NCH-1:0] out;

  pwm_multi_if bus ();

  pwm_multi #(.NCH(NCH), .CNT_W(16), .PRE_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .out    (out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit rd; logic [31:0] exp; string nm; } bus_exp_t;
  typedef struct { logic [31:0] act; logic [31:0] exp; string nm; } chk_t;

  bus_exp_t       bq[$];
  chk_t           cq[$];
  logic [NCH-1:0] pq[$];
  int             pwm_start = 32'h7fffffff;
  int             tests = 0;
  int             fails = 0;

  // Monitor: owns all counting.
  always @(negedge clk) begin
    bus_exp_t       be;
    chk_t           c;
    logic [NCH-1:0] pe;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      tests++;
      if (c.act !== c.exp) begin
        fails++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", c.nm, c.act, c.exp);
      end
    end
    if (bus.ready === 1'b1) begin
      tests++;
      if (bq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: got ready=1 expected 0");
      end else begin
        be = bq.pop_front();
        if (be.rd && bus.rdata !== be.exp) begin
          fails++;
          $display("FAIL %s: got rdata 0x%0h expected 0x%0h", be.nm, bus.rdata, be.exp);
        end
      end
    end
    if (cyc >= pwm_start && pq.size() > 0) begin
      pe = pq.pop_front();
      tests++;
      if (out !== pe) begin
        fails++;
        $display("FAIL pwm_out@%0d: got %b expected %b", cyc - pwm_start + 1, out, pe);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: counter k clocks after the EN-setting edge.
  function automatic int cnt_at(input int k, input int P, input int S);
    return (k / (S + 1)) % (P + 1);
  endfunction

  // Output after edge E+k; duty register changes to dnew at edge E+ka and
  // the comparators only see it from the first wrap strictly after that.
  function automatic logic [NCH-1:0] exp_out(input int k, input int P, input int S,
                                             input int dold[NCH], input int dnew[NCH],
                                             input int ka);
    logic [NCH-1:0] v;
    int j, plen, w, act;
    v = '0;
    if (k < 1) return v;
    j    = k - 1;
    plen = (P + 1) * (S + 1);
    w    = (j / plen) * plen;
    for (int i = 0; i < NCH; i++) begin
      act  = (w > 0 && w > ka) ? dnew[i] : dold[i];
      v[i] = (cnt_at(j, P, S) < act);
    end
    return v;
  endfunction

  task automatic push_chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.nm = nm; c.act = act; c.exp = exp;
    cq.push_back(c);
  endtask

  // Starts at a negedge with ready low; returns #1 after the cycle following accept.
  task automatic xfer_now(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] exp, input string nm, output int acc);
    bus_exp_t e;
    bit got;
    got = 0;
    acc = -1;
    e.rd = (s == 4'b0000); e.exp = exp; e.nm = nm;
    bq.push_back(e);
    bus.addr = a; bus.wdata = d; bus.wstrb = s; bus.valid = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) begin got = 1; acc = cyc; end
    end
    bus.valid = 1'b0;
    if (!got) push_chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp, input string nm, output int acc);
    @(negedge clk);
    xfer_now(a, d, s, exp, nm, acc);
  endtask

  task automatic read_status(input int E, input int P, input int S);
    int a;
    @(negedge clk);
    xfer_now(32'h08, 32'h0, 4'h0, 32'(cnt_at(cyc - E, P, S)), "status", a);
  endtask

  task automatic start_pwm(input int P, input int S, input int d[NCH], output int E);
    int a;
    xfer(32'h00, 32'h0, 4'hF, 32'h0, "cfg_ctrl", a);
    xfer(32'h04, 32'(P), 4'hF, 32'h0, "cfg_period", a);
    for (int i = 0; i < NCH; i++) xfer(32'h40 + 32'(4 * i), 32'(d[i]), 4'hF, 32'h0, "cfg_duty", a);
    xfer(32'h00, 32'((S << 8) | 1), 4'hF, 32'h0, "cfg_en", E);
  endtask

  task automatic push_stream(input int E, input int P, input int S, input int dold[NCH],
                             input int dnew[NCH], input int ka, input int n);
    for (int k = 1; k <= n; k++) pq.push_back(exp_out(k, P, S, dold, dnew, ka));
    pwm_start = E + 1;
  endtask

  task automatic wait_stream();
    for (int i = 0; i < 3000 && pq.size() > 0; i++) @(negedge clk);
    #1;
    if (pq.size() > 0) begin
      push_chk("stream_timeout", 32'(pq.size()), 32'd0);
      pq.delete();
    end
  endtask

  initial begin
    int E, a, P, S;
    int d[NCH];
    int dn[NCH];
    logic [5:0] pat;
    bus.valid = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;

    repeat (3) @(posedge clk);
    #1;
    push_chk("init_out", 32'(out), 32'h0);
    push_chk("init_ready", 32'(bus.ready), 32'h0);
    @(negedge clk); resetn = 1'b1;

    // Basic duty, including duty 0 and duty above PERIOD.
    d = '{3, 0, 10, 5};
    start_pwm(9, 0, d, E);
    push_stream(E, 9, 0, d, d, 1 << 30, 30);
    wait_stream();

    // Reset while running.
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    push_chk("rst_out", 32'(out), 32'h0);
    push_chk("rst_ready", 32'(bus.ready), 32'h0);
    @(negedge clk); resetn = 1'b1;
    xfer(32'h00, 32'h0, 4'h0, 32'h0, "rst_ctrl", a);
    xfer(32'h04, 32'h0, 4'h0, 32'h0, "rst_period", a);
    xfer(32'h40, 32'h0, 4'h0, 32'h0, "rst_duty0", a);
    xfer(32'h08, 32'h0, 4'h0, 32'h0, "rst_status", a);

    // Duty update mid-period, accepted while the counter reads 5.
    d = '{2, 0, 0, 0}; dn = '{7, 0, 0, 0};
    start_pwm(9, 0, d, E);
    push_stream(E, 9, 0, d, dn, 6, 30);
    repeat (5) @(negedge clk);
    xfer_now(32'h40, 32'd7, 4'hF, 32'h0, "duty_upd", a);
    push_chk("duty_upd_cycle", 32'(a - E), 32'd6);
    wait_stream();

    // Prescaler.
    d = '{2, 1, 6, 0};
    start_pwm(4, 3, d, E);
    push_stream(E, 4, 3, d, d, 1 << 30, 45);
    read_status(E, 4, 3);
    repeat (3) @(negedge clk);
    read_status(E, 4, 3);
    wait_stream();

    // Bus handshake with valid held for six clocks.
    xfer(32'h00, 32'h0, 4'hF, 32'h0, "hs_dis", a);
    xfer(32'h40, 32'h1234, 4'hF, 32'h0, "hs_pre", a);
    for (int i = 0; i < 3; i++) begin
      bus_exp_t e;
      e.rd = 1'b0; e.exp = '0; e.nm = "hs_write";
      bq.push_back(e);
    end
    @(negedge clk);
    bus.addr = 32'h40; bus.wdata = 32'h0000AB00; bus.wstrb = 4'b0010; bus.valid = 1'b1;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat[i] = bus.ready;
    end
    bus.valid = 1'b0;
    push_chk("hs_pattern", 32'(pat), 32'h15);
    xfer(32'h40, 32'h0, 4'h0, 32'h0000AB34, "hs_duty0", a);
    xfer(32'h3C, 32'hFFFFFFFF, 4'hF, 32'h0, "unmapped_wr", a);
    xfer(32'h3C, 32'h0, 4'h0, 32'h0, "unmapped_rd", a);
    xfer(32'h00, 32'hFFFFFFFF, 4'hF, 32'h0, "ctrl_all", a);
`ifdef PWM_CENTER_ALIGN_EN
    xfer(32'h00, 32'h0, 4'h0, 32'h0000FF03, "ctrl_rd", a);
`else
    xfer(32'h00, 32'h0, 4'h0, 32'h0000FF01, "ctrl_rd", a);
`endif
    xfer(32'h04, 32'hFFFFFFFF, 4'hF, 32'h0, "period_all", a);
    xfer(32'h04, 32'h0, 4'h0, 32'h0000FFFF, "period_rd", a);

    // PERIOD lowered below the running counter: no wrap until the counter overflows.
    d = '{0, 0, 0, 0};
    start_pwm(9, 0, d, E);
    repeat (8) @(negedge clk);
    xfer_now(32'h04, 32'd3, 4'hF, 32'h0, "period_low", a);
    repeat (20) @(negedge clk);
    read_status(E, 65535, 0);
    xfer(32'h00, 32'h0, 4'hF, 32'h0, "period_low_dis", a);
    xfer(32'h08, 32'h0, 4'h0, 32'h0, "status_dis", a);

    // Randomized configurations.
    for (int it = 0; it < 6; it++) begin
      P = int'($urandom_range(0, 12));
      S = int'($urandom_range(0, 3));
      for (int i = 0; i < NCH; i++) d[i] = int'($urandom_range(0, P + 2));
      start_pwm(P, S, d, E);
      push_stream(E, P, S, d, d, 1 << 30, 2 * (P + 1) * (S + 1) + 4);
      read_status(E, P, S);
      wait_stream();
      xfer(32'h00, 32'h0, 4'hF, 32'h0, "rand_dis", a);
      push_chk("dis_out", 32'(out), 32'h0);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
